// File: rtl/atpg_entry_ctl.sv
// ATPG test-entry controller: synchronizes the TST/SCL/SDA pads, checks a
// serial entry key and mode byte, and drives the scan pin-mux enable.
//
// Parameters:
//   KEY    test-entry key, shifted MSB first
//   TMO    SCL-idle timeout in clk cycles while shifting key/mode bits
//   NMODE  number of legal mode codes (0x01..NMODE)
//
// Ports:
//   clk      system clock, rising edge
//   srst     synchronous active-high reset
//   tst_pin  raw TST pad level (asynchronous)
//   scl_pin  raw SCL pad level (asynchronous), shift strobe
//   sda_pin  raw SDA pad level (asynchronous), serial data
//   atpg_en  scan/ATPG pin-mux enable (mode 0x01 only)
//   tm_sel   latched mode byte, valid while test_act=1
//   test_act test mode active
//   key_err  sticky key/mode error flag
//   st_o     FSM state encoding for debug
module atpg_entry_ctl #(
    parameter logic [15:0] KEY   = 16'hA5C3,
    parameter int unsigned TMO   = 1024,
    parameter int unsigned NMODE = 4
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       tst_pin,
    input  logic       scl_pin,
    input  logic       sda_pin,
    output logic       atpg_en,
    output logic [7:0] tm_sel,
    output logic       test_act,
    output logic       key_err,
    output logic [2:0] st_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEY    = 3'd1;
    localparam logic [2:0] S_MODE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_LOCK   = 3'd4;

    localparam logic [9:0] TMO_LAST = 10'(TMO - 1);
    localparam logic [7:0] NMODE_B  = 8'(NMODE);

    // Pad synchronizers
    logic tst_s1_q, tst_s2_q;
    logic scl_s1_q, scl_s2_q;
    logic sda_s1_q, sda_s2_q;
    logic scl_prev_q;

    logic [2:0]  state_q,    state_d;
    logic [15:0] shift_q,    shift_d;
    logic [4:0]  bcnt_q,     bcnt_d;
    logic [9:0]  tmo_q,      tmo_d;
    logic [1:0]  low_q,      low_d;
    logic [7:0]  tm_sel_q,   tm_sel_d;
    logic        test_act_q, test_act_d;
    logic        atpg_en_q,  atpg_en_d;
    logic        key_err_q,  key_err_d;

    logic        scl_rise;
    logic [15:0] shift_nx;
    logic        shifting;
    logic        tst_exit;
    logic        tmo_hit;
    logic        mode_ok;

    assign scl_rise = scl_s2_q & ~scl_prev_q;
    assign shift_nx = {shift_q[14:0], sda_s2_q};
    assign shifting = (state_q == S_KEY) || (state_q == S_MODE);

    // low_q==3 with TST still low marks the 4th consecutive low cycle
    assign tst_exit = (state_q != S_IDLE) && !tst_s2_q && (low_q == 2'd3);
    assign tmo_hit  = shifting && (tmo_q == TMO_LAST);
    assign mode_ok  = (shift_nx[7:0] != 8'h00) && (shift_nx[7:0] <= NMODE_B);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        tm_sel_d   = tm_sel_q;
        test_act_d = test_act_q;
        atpg_en_d  = atpg_en_q;
        key_err_d  = key_err_q;

        if (state_q == S_IDLE || tst_s2_q) begin
            low_d = 2'd0;
        end else begin
            low_d = low_q + 2'd1;
        end

        if (!shifting) begin
            tmo_d = tmo_q;
        end else if (scl_rise) begin
            tmo_d = 10'd0;
        end else begin
            tmo_d = tmo_q + 10'd1;
        end

        if (tst_exit || tmo_hit) begin
            // Leaving to IDLE: drop outputs in the same transition,
            // key_err is left untouched.
            state_d    = S_IDLE;
            tm_sel_d   = 8'h00;
            test_act_d = 1'b0;
            atpg_en_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tst_s2_q) begin
                        state_d   = S_KEY;
                        shift_d   = 16'h0000;
                        bcnt_d    = 5'd0;
                        tmo_d     = 10'd0;
                        key_err_d = 1'b0;
                    end
                end
                S_KEY: begin
                    if (scl_rise) begin
                        shift_d = shift_nx;
                        bcnt_d  = bcnt_q + 5'd1;
                        if (bcnt_q == 5'd15) begin
                            if (shift_nx == KEY) begin
                                state_d = S_MODE;
                                bcnt_d  = 5'd0;
                            end else begin
                                state_d   = S_LOCK;
                                key_err_d = 1'b1;
                            end
                        end
                    end
                end
                S_MODE: begin
                    if (scl_rise) begin
                        shift_d = shift_nx;
                        bcnt_d  = bcnt_q + 5'd1;
                        if (bcnt_q == 5'd7) begin
                            if (mode_ok) begin
                                state_d    = S_ACTIVE;
                                tm_sel_d   = shift_nx[7:0];
                                test_act_d = 1'b1;
                                atpg_en_d  = (shift_nx[7:0] == 8'h01);
                            end else begin
                                state_d   = S_LOCK;
                                key_err_d = 1'b1;
                            end
                        end
                    end
                end
                S_ACTIVE: begin
                    state_d = S_ACTIVE;
                end
                S_LOCK: begin
                    state_d = S_LOCK;
                end
                default: begin
                    state_d    = S_IDLE;
                    tm_sel_d   = 8'h00;
                    test_act_d = 1'b0;
                    atpg_en_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tst_s1_q   <= 1'b0;
            tst_s2_q   <= 1'b0;
            scl_s1_q   <= 1'b0;
            scl_s2_q   <= 1'b0;
            sda_s1_q   <= 1'b0;
            sda_s2_q   <= 1'b0;
            scl_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            shift_q    <= 16'h0000;
            bcnt_q     <= 5'd0;
            tmo_q      <= 10'd0;
            low_q      <= 2'd0;
            tm_sel_q   <= 8'h00;
            test_act_q <= 1'b0;
            atpg_en_q  <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            tst_s1_q   <= tst_pin;
            tst_s2_q   <= tst_s1_q;
            scl_s1_q   <= scl_pin;
            scl_s2_q   <= scl_s1_q;
            sda_s1_q   <= sda_pin;
            sda_s2_q   <= sda_s1_q;
            scl_prev_q <= scl_s2_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            tmo_q      <= tmo_d;
            low_q      <= low_d;
            tm_sel_q   <= tm_sel_d;
            test_act_q <= test_act_d;
            atpg_en_q  <= atpg_en_d;
            key_err_q  <= key_err_d;
        end
    end

    assign atpg_en  = atpg_en_q;
    assign tm_sel   = tm_sel_q;
    assign test_act = test_act_q;
    assign key_err  = key_err_q;
    assign st_o     = state_q;

endmodule

// File: tb/tb_atpg_entry_ctl.sv
// Directed bench for atpg_entry_ctl.
// Inputs driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_atpg_entry_ctl;

    logic       clk = 1'b0;
    logic       srst;
    logic       tst_pin;
    logic       scl_pin;
    logic       sda_pin;
    logic       atpg_en;
    logic [7:0] tm_sel;
    logic       test_act;
    logic       key_err;
    logic [2:0] st_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    atpg_entry_ctl dut (
        .clk      (clk),
        .srst     (srst),
        .tst_pin  (tst_pin),
        .scl_pin  (scl_pin),
        .sda_pin  (sda_pin),
        .atpg_en  (atpg_en),
        .tm_sel   (tm_sel),
        .test_act (test_act),
        .key_err  (key_err),
        .st_o     (st_o)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift v[n-1:0] MSB first, one SCL pulse per bit
    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sda_pin = v[i];
            tick(3);
            scl_pin = 1'b1;
            tick(3);
            scl_pin = 1'b0;
            tick(3);
        end
    endtask

    task automatic enter();
        tst_pin = 1'b1;
        tick(4);
    endtask

    task automatic leave();
        tst_pin = 1'b0;
        tick(7);
    endtask

    initial begin
        int n;
        logic seen;

        srst    = 1'b1;
        tst_pin = 1'b0;
        scl_pin = 1'b0;
        sda_pin = 1'b0;
        tick(3);
        chk("rst_st", 32'(st_o), 32'd0);
        chk("rst_atpg", 32'(atpg_en), 32'd0);
        chk("rst_tmsel", 32'(tm_sel), 32'h00);
        chk("rst_act", 32'(test_act), 32'd0);
        chk("rst_err", 32'(key_err), 32'd0);
        srst = 1'b0;
        tick(2);

        // Good key + mode 01
        enter();
        chk("s1_key", 32'(st_o), 32'd1);
        shift_bits(16'hA5C3, 16);
        chk("s1_mode", 32'(st_o), 32'd2);
        shift_bits(16'h0000, 7);
        sda_pin = 1'b1;
        tick(3);
        scl_pin = 1'b1;
        tick(4);
        chk("s1_st", 32'(st_o), 32'd3);
        chk("s1_act", 32'(test_act), 32'd1);
        chk("s1_atpg", 32'(atpg_en), 32'd1);
        chk("s1_tmsel", 32'(tm_sel), 32'h01);
        scl_pin = 1'b0;
        tick(3);
        shift_bits(16'hFFFF, 16);
        chk("act_ign_st", 32'(st_o), 32'd3);
        chk("act_ign_sel", 32'(tm_sel), 32'h01);

        // 3-clk TST glitch ignored, 4-clk low exits
        tst_pin = 1'b0;
        tick(3);
        tst_pin = 1'b1;
        tick(6);
        chk("glitch_st", 32'(st_o), 32'd3);
        chk("glitch_act", 32'(test_act), 32'd1);
        leave();
        chk("exit_st", 32'(st_o), 32'd0);
        chk("exit_act", 32'(test_act), 32'd0);
        chk("exit_atpg", 32'(atpg_en), 32'd0);
        chk("exit_sel", 32'(tm_sel), 32'h00);

        // Bad key A5C2
        enter();
        shift_bits(16'hA5C2, 16);
        chk("bk_st", 32'(st_o), 32'd4);
        chk("bk_err", 32'(key_err), 32'd1);
        chk("bk_act", 32'(test_act), 32'd0);
        chk("bk_atpg", 32'(atpg_en), 32'd0);
        shift_bits(16'hA5C3, 16);
        chk("lock_ign", 32'(st_o), 32'd4);
        leave();
        chk("bk_idle", 32'(st_o), 32'd0);
        chk("bk_sticky", 32'(key_err), 32'd1);
        enter();
        chk("bk_rekey", 32'(st_o), 32'd1);
        chk("bk_clr", 32'(key_err), 32'd0);

        // Illegal mode 07
        shift_bits(16'hA5C3, 16);
        shift_bits(16'h0007, 8);
        chk("m7_st", 32'(st_o), 32'd4);
        chk("m7_err", 32'(key_err), 32'd1);
        chk("m7_atpg", 32'(atpg_en), 32'd0);
        chk("m7_sel", 32'(tm_sel), 32'h00);
        leave();

        // Mode 00 is illegal
        enter();
        shift_bits(16'hA5C3, 16);
        shift_bits(16'h0000, 8);
        chk("m0_st", 32'(st_o), 32'd4);
        leave();

        // Mode 03
        enter();
        shift_bits(16'hA5C3, 16);
        shift_bits(16'h0003, 8);
        chk("m3_st", 32'(st_o), 32'd3);
        chk("m3_atpg", 32'(atpg_en), 32'd0);
        chk("m3_sel", 32'(tm_sel), 32'h03);
        chk("m3_act", 32'(test_act), 32'd1);
        chk("m3_err", 32'(key_err), 32'd0);
        leave();

        // Mode 04 (= NMODE) is the last legal code
        enter();
        shift_bits(16'hA5C3, 16);
        shift_bits(16'h0004, 8);
        chk("m4_st", 32'(st_o), 32'd3);
        chk("m4_sel", 32'(tm_sel), 32'h04);
        leave();

        // SCL timeout after 9 key bits
        enter();
        shift_bits(16'hA5C3 >> 7, 9);
        n = 0;
        seen = 1'b0;
        while (n < 1100 && !seen) begin
            tick(1);
            n++;
            if (st_o == 3'd0) seen = 1'b1;
        end
        chk("tmo_seen", 32'(seen), 32'd1);
        chk("tmo_win", 32'(n >= 1000 && n <= 1040), 32'd1);
        chk("tmo_err", 32'(key_err), 32'd0);
        tick(2);
        chk("tmo_rekey", 32'(st_o), 32'd1);
        shift_bits(16'hA5C3, 16);
        shift_bits(16'h0002, 8);
        chk("tmo_full", 32'(st_o), 32'd3);
        chk("tmo_sel", 32'(tm_sel), 32'h02);
        leave();

        // srst at 12th key bit
        enter();
        shift_bits(16'hA5C3 >> 5, 11);
        sda_pin = 1'b0;
        tick(1);
        srst = 1'b1;
        tick(1);
        chk("sr_st", 32'(st_o), 32'd0);
        chk("sr_err", 32'(key_err), 32'd0);
        chk("sr_act", 32'(test_act), 32'd0);
        chk("sr_atpg", 32'(atpg_en), 32'd0);
        chk("sr_sel", 32'(tm_sel), 32'h00);
        srst = 1'b0;
        tick(4);
        chk("sr_rekey", 32'(st_o), 32'd1);
        shift_bits(16'hA5C3, 16);
        shift_bits(16'h0001, 8);
        chk("sr_full", 32'(st_o), 32'd3);
        chk("sr_atpg1", 32'(atpg_en), 32'd1);

        // srst in ACTIVE
        srst = 1'b1;
        tick(1);
        chk("sra_st", 32'(st_o), 32'd0);
        chk("sra_act", 32'(test_act), 32'd0);
        chk("sra_sel", 32'(tm_sel), 32'h00);
        srst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
